// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_arbiter
// Description : Shares one single-ported unified memory between instruction
//               fetch and the memory stage (loads/stores). One transaction is
//               outstanding at a time. Data accesses win by default. A
//               saturating starvation counter forces one fetch grant after
//               STARVE_MAX consecutive fetch losses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   if_req/if_addr  : fetch read request and PC
//   dm_cmd/dm_addr/dm_wdata : memory-stage command (00 none, 01 load,
//                     10 store, 11 treated as none), address, store data
//   proc2mem_*      : command/address/data toward memory (issue cycle only)
//   mem2proc_*      : completion strobe and read data from memory
//   if_done/if_data : fetch completion pulse and instruction word
//   dm_done/dm_rdata: data completion pulse and load data (0 for stores)
//   spurious_rsp    : sticky flag, memory response seen while idle
// ============================================================================
module imem_dmem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic [1:0]  dm_cmd,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [1:0]  proc2mem_cmd,
    output logic [31:0] proc2mem_addr,
    output logic [31:0] proc2mem_data,
    input  logic        mem2proc_valid,
    input  logic [31:0] mem2proc_data,
    output logic        if_done,
    output logic [31:0] if_data,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        spurious_rsp
);

    // FSM encoding
    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_BUSY_I = 2'd1;
    localparam logic [1:0] C_BUSY_D = 2'd2;

    // Memory command encoding
    localparam logic [1:0] C_CMD_NONE  = 2'b00;
    localparam logic [1:0] C_CMD_LOAD  = 2'b01;
    localparam logic [1:0] C_CMD_STORE = 2'b10;

    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] C_CNT_SAT    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             is_load_q, is_load_d;   // remembers load vs store for dm_rdata
    logic             spur_q, spur_d;

    logic             w_dm_req;
    logic             w_data_wins;
    logic [31:0]      w_if_addr_al;
    logic [31:0]      w_dm_addr_al;

    // Low address bits are deliberately dropped on issue.
    logic             w_unused_addr_bits;
    assign w_unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

    assign w_dm_req     = (dm_cmd == C_CMD_LOAD) || (dm_cmd == C_CMD_STORE);
    assign w_if_addr_al = {if_addr[31:2], 2'b00};
    assign w_dm_addr_al = {dm_addr[31:2], 2'b00};

    // Data wins unless fetch is also waiting and has already lost
    // STARVE_MAX arbitrations in a row.
    assign w_data_wins  = w_dm_req && (!if_req || (starve_q < C_STARVE_MAX));

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        is_load_d     = is_load_q;
        spur_d        = spur_q;
        proc2mem_cmd  = C_CMD_NONE;
        proc2mem_addr = 32'h0;
        proc2mem_data = 32'h0;
        if_done       = 1'b0;
        if_data       = 32'h0;
        dm_done       = 1'b0;
        dm_rdata      = 32'h0;

        case (state_q)
            C_IDLE: begin
                // A response with nothing outstanding is dropped but flagged.
                if (mem2proc_valid) begin
                    spur_d = 1'b1;
                end
                if (w_data_wins) begin
                    proc2mem_cmd  = dm_cmd;
                    proc2mem_addr = w_dm_addr_al;
                    proc2mem_data = (dm_cmd == C_CMD_STORE) ? dm_wdata : 32'h0;
                    is_load_d     = (dm_cmd == C_CMD_LOAD);
                    state_d       = C_BUSY_D;
                    // Only a loss while fetch is actually waiting counts.
                    if (if_req && (starve_q != C_CNT_SAT)) begin
                        starve_d = starve_q + C_CNT_ONE;
                    end
                end else if (if_req) begin
                    proc2mem_cmd  = C_CMD_LOAD;
                    proc2mem_addr = w_if_addr_al;
                    starve_d      = '0;
                    state_d       = C_BUSY_I;
                end
            end
            C_BUSY_I: begin
                if (mem2proc_valid) begin
                    if_done = 1'b1;
                    if_data = mem2proc_data;
                    state_d = C_IDLE;
                end
            end
            C_BUSY_D: begin
                if (mem2proc_valid) begin
                    dm_done  = 1'b1;
                    dm_rdata = is_load_q ? mem2proc_data : 32'h0;
                    state_d  = C_IDLE;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase

        // Outputs stay quiet for the whole reset cycle, even mid-transaction.
        if (rst) begin
            proc2mem_cmd  = C_CMD_NONE;
            proc2mem_addr = 32'h0;
            proc2mem_data = 32'h0;
            if_done       = 1'b0;
            if_data       = 32'h0;
            dm_done       = 1'b0;
            dm_rdata      = 32'h0;
        end
    end

    assign spurious_rsp = spur_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= C_IDLE;
            starve_q  <= '0;
            is_load_q <= 1'b0;
            spur_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            is_load_q <= is_load_d;
            spur_q    <= spur_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_dmem_arbiter
// Description : Self-checking bench for imem_dmem_arbiter. A table of
//               per-cycle vectors covers reset, fetch, load/fetch contention,
//               store, reset mid-transaction and spurious responses; hand
//               sequences cover starvation and a latency sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [1:0]  dm_cmd;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  proc2mem_cmd;
    logic [31:0] proc2mem_addr;
    logic [31:0] proc2mem_data;
    logic        mem2proc_valid;
    logic [31:0] mem2proc_data;
    logic        if_done;
    logic [31:0] if_data;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        spurious_rsp;

    int n_total = 0;
    int n_pass  = 0;

    imem_dmem_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .dm_cmd         (dm_cmd),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .proc2mem_cmd   (proc2mem_cmd),
        .proc2mem_addr  (proc2mem_addr),
        .proc2mem_data  (proc2mem_data),
        .mem2proc_valid (mem2proc_valid),
        .mem2proc_data  (mem2proc_data),
        .if_done        (if_done),
        .if_data        (if_data),
        .dm_done        (dm_done),
        .dm_rdata       (dm_rdata),
        .spurious_rsp   (spurious_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic [1:0]  dm_cmd;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        mv;
        logic [31:0] mdata;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [31:0] e_pdata;
        logic        e_if_done;
        logic [31:0] e_if_data;
        logic        e_dm_done;
        logic [31:0] e_dm_rdata;
        logic        e_spur;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t V(
        input logic r, input logic ir, input logic [31:0] ia,
        input logic [1:0] dc, input logic [31:0] da, input logic [31:0] dw,
        input logic mv, input logic [31:0] md,
        input logic [1:0] ec, input logic [31:0] ea, input logic [31:0] ep,
        input logic eid, input logic [31:0] eidat,
        input logic edd, input logic [31:0] eddat, input logic es);
        vec_t v;
        v.rst = r;  v.if_req = ir; v.if_addr = ia;
        v.dm_cmd = dc; v.dm_addr = da; v.dm_wdata = dw;
        v.mv = mv; v.mdata = md;
        v.e_cmd = ec; v.e_addr = ea; v.e_pdata = ep;
        v.e_if_done = eid; v.e_if_data = eidat;
        v.e_dm_done = edd; v.e_dm_rdata = eddat; v.e_spur = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        dm_cmd = 2'b00; dm_addr = 32'h0; dm_wdata = 32'h0;
        mv_set(1'b0, 32'h0);
    endtask

    task automatic mv_set(input logic v, input logic [31:0] d);
        mem2proc_valid = v;
        mem2proc_data  = d;
    endtask

    initial begin
        int   lats[3];
        int   cnt;
        logic exp_data;
        lats[0] = 1; lats[1] = 2; lats[2] = 7;

        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        dm_cmd = 2'b00; dm_addr = 32'h0; dm_wdata = 32'h0;
        mem2proc_valid = 1'b0; mem2proc_data = 32'h0;

        //            rst ir  if_addr      dc     dm_addr      dm_wdata     mv  mdata         e_cmd  e_addr       e_pdata      eid e_if_data    edd e_dm_rdata   es
        // reset and idle
        vecs.push_back(V(1, 0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(0, 0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        // fetch at 0x6, response 3 cycles after issue
        vecs.push_back(V(0, 1, 32'h6,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b01, 32'h4,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(0, 1, 32'h6,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(0, 1, 32'h6,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(0, 1, 32'h6,        2'b00, 32'h0,       32'h0,       1, 32'hDEADBEEF, 2'b00, 32'h0,       32'h0,       1, 32'hDEADBEEF, 0, 32'h0,      0));
        vecs.push_back(V(0, 0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        // load and fetch together: load first, fetch in IDLE after dm_done
        vecs.push_back(V(0, 1, 32'h20,       2'b01, 32'h43,      32'h0,       0, 32'h0,        2'b01, 32'h40,      32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(0, 1, 32'h20,       2'b01, 32'h43,      32'h0,       1, 32'h11111111, 2'b00, 32'h0,       32'h0,       0, 32'h0,       1, 32'h11111111, 0));
        vecs.push_back(V(0, 1, 32'h20,       2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b01, 32'h20,      32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(0, 1, 32'h20,       2'b00, 32'h0,       32'h0,       1, 32'h22222222, 2'b00, 32'h0,       32'h0,       1, 32'h22222222, 0, 32'h0,      0));
        // store, ack 2 cycles after issue; dm_rdata stays 0
        vecs.push_back(V(0, 0, 32'h0,        2'b10, 32'h102,     32'h12345678, 0, 32'h0,       2'b10, 32'h100,     32'h12345678, 0, 32'h0,      0, 32'h0,       0));
        vecs.push_back(V(0, 0, 32'h0,        2'b10, 32'h102,     32'h12345678, 0, 32'h0,       2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(0, 0, 32'h0,        2'b10, 32'h102,     32'h12345678, 1, 32'hAAAA5555, 2'b00, 32'h0,      32'h0,       0, 32'h0,       1, 32'h0,       0));
        vecs.push_back(V(0, 0, 32'h0,        2'b11, 32'h0,       32'h0,       0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        // load issued, reset in BUSY_D, late response becomes spurious
        vecs.push_back(V(0, 0, 32'h0,        2'b01, 32'h200,     32'h0,       0, 32'h0,        2'b01, 32'h200,     32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(1, 0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(0, 0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(0, 0, 32'h0,        2'b00, 32'h0,       32'h0,       1, 32'h55555555, 2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(0, 0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       1));
        // flag survives normal traffic, clears on rst
        vecs.push_back(V(0, 1, 32'h8,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b01, 32'h8,       32'h0,       0, 32'h0,       0, 32'h0,       1));
        vecs.push_back(V(0, 1, 32'h8,        2'b00, 32'h0,       32'h0,       1, 32'h0BADF00D, 2'b00, 32'h0,       32'h0,       1, 32'h0BADF00D, 0, 32'h0,      1));
        vecs.push_back(V(1, 0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(V(0, 0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,        2'b00, 32'h0,       32'h0,       0, 32'h0,       0, 32'h0,       0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            dm_cmd = vecs[i].dm_cmd; dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
            mv_set(vecs[i].mv, vecs[i].mdata);
            #1;
            check($sformatf("v%0d cmd", i),      {30'b0, proc2mem_cmd},  {30'b0, vecs[i].e_cmd});
            check($sformatf("v%0d addr", i),     proc2mem_addr,          vecs[i].e_addr);
            check($sformatf("v%0d pdata", i),    proc2mem_data,          vecs[i].e_pdata);
            check($sformatf("v%0d if_done", i),  {31'b0, if_done},       {31'b0, vecs[i].e_if_done});
            check($sformatf("v%0d if_data", i),  if_data,                vecs[i].e_if_data);
            check($sformatf("v%0d dm_done", i),  {31'b0, dm_done},       {31'b0, vecs[i].e_dm_done});
            check($sformatf("v%0d dm_rdata", i), dm_rdata,               vecs[i].e_dm_rdata);
            check($sformatf("v%0d spur", i),     {31'b0, spurious_rsp},  {31'b0, vecs[i].e_spur});
        end

        // Starvation: fetch and store both held, latency 1.
        // Expected grants: D D D D I D, counter 1 2 3 4 0 1.
        drive_idle();
        cnt = 0;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h1000;
            dm_cmd = 2'b10; dm_addr = 32'h3000; dm_wdata = 32'hC0DE0000 + g;
            mv_set(1'b0, 32'h0);
            #1;
            exp_data = (cnt < 4);
            check($sformatf("starve g%0d cmd", g),  {30'b0, proc2mem_cmd}, exp_data ? 32'd2 : 32'd1);
            check($sformatf("starve g%0d addr", g), proc2mem_addr, exp_data ? 32'h3000 : 32'h1000);
            if (exp_data) cnt = (cnt == 7) ? 7 : cnt + 1;
            else          cnt = 0;
            @(negedge clk);
            mv_set(1'b1, 32'h77770000 + g);
            #1;
            check($sformatf("starve g%0d dm_done", g), {31'b0, dm_done}, {31'b0, exp_data});
            check($sformatf("starve g%0d if_done", g), {31'b0, if_done}, {31'b0, ~exp_data});
            check($sformatf("starve g%0d counter", g), 32'(dut.starve_q), cnt);
        end

        // Latency sweep with alternating requesters.
        @(negedge clk);
        drive_idle();
        for (int p = 0; p < 6; p++) begin
            logic is_fetch;
            is_fetch = (p % 2 == 0);
            @(negedge clk);
            mv_set(1'b0, 32'h0);
            if (is_fetch) begin
                if_req = 1'b1; if_addr = 32'h4000 + 32'(p * 8) + 32'h3;
            end else begin
                dm_cmd = 2'b01; dm_addr = 32'h8000 + 32'(p * 8) + 32'h1;
            end
            #1;
            check($sformatf("sweep p%0d issue cmd", p), {30'b0, proc2mem_cmd}, 32'd1);
            check($sformatf("sweep p%0d issue addr", p), proc2mem_addr,
                  is_fetch ? 32'h4000 + 32'(p * 8) : 32'h8000 + 32'(p * 8));
            for (int c = 1; c < lats[p % 3]; c++) begin
                @(negedge clk);
                #1;
                check($sformatf("sweep p%0d wait%0d cmd", p, c), {30'b0, proc2mem_cmd}, 32'd0);
                check($sformatf("sweep p%0d wait%0d dones", p, c), {30'b0, if_done, dm_done}, 32'd0);
            end
            @(negedge clk);
            mv_set(1'b1, 32'hABC00000 + 32'(p));
            #1;
            check($sformatf("sweep p%0d rsp dones", p), {30'b0, if_done, dm_done},
                  is_fetch ? 32'd2 : 32'd1);
            check($sformatf("sweep p%0d rsp data", p), is_fetch ? if_data : dm_rdata,
                  32'hABC00000 + 32'(p));
            check($sformatf("sweep p%0d rsp cmd", p), {30'b0, proc2mem_cmd}, 32'd0);
            @(negedge clk);
            drive_idle();
            #1;
            check($sformatf("sweep p%0d idle", p), {29'b0, proc2mem_cmd, if_done | dm_done}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
